// File: rtl/ucode_issue_ctrl.sv
// MUL issue controller between IF and ID: removes MUL from the fetch stream, starts the
// microcode sequencer and muxes its output into ID. Optional checker: UCODE_ISSUE_CHECK_EN.
module ucode_issue_ctrl #(
    parameter logic [6:0]  MUL_OPCODE = 7'b0110011,
    parameter logic [31:0] NOP_INSTR  = 32'hC800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    output logic        if_ready,
    output logic        start_mul,
    output logic [3:0]  dest_reg,
    output logic [3:0]  source_reg,
    output logic [15:0] immediate,
    input  logic [31:0] ucode_instr,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        ucode_busy
`ifdef UCODE_ISSUE_CHECK_EN
    ,
    output logic        ucode_err
`endif
);

    typedef enum logic [1:0] {
        ST_PASS   = 2'd0,
        ST_INJECT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [16:0]   cnt_r;
    logic [3:0]    rd_r;
    logic [3:0]    rs_r;
    logic [15:0]   imm_r;
    logic          is_mul_s;
    logic          pass_valid_s;

    assign is_mul_s     = (if_instr[31:25] == MUL_OPCODE);
    assign pass_valid_s = if_valid & ~is_mul_s;

    // Output mux; outputs are held at their reset values while rst is asserted
    always_comb begin
        if_ready   = 1'b0;
        start_mul  = 1'b0;
        id_valid   = 1'b0;
        id_instr   = NOP_INSTR;
        dest_reg   = rd_r;
        source_reg = rs_r;
        immediate  = imm_r;
        ucode_busy = 1'b0;
        if (rst) begin
            if_ready = 1'b0;
        end else begin
            case (state_r)
                ST_PASS: begin
                    if_ready   = 1'b1;
                    start_mul  = if_valid & is_mul_s;
                    id_valid   = pass_valid_s;
                    id_instr   = pass_valid_s ? if_instr : NOP_INSTR;
                    dest_reg   = if_instr[24:21];
                    source_reg = if_instr[20:17];
                    immediate  = if_instr[15:0];
                end
                ST_INJECT: begin
                    id_valid   = 1'b1;
                    id_instr   = ucode_instr;
                    ucode_busy = 1'b1;
                end
                ST_DRAIN: begin
                    ucode_busy = 1'b1;
                end
                default: begin
                    ucode_busy = 1'b0;
                end
            endcase
        end
    end

    // State, remaining-instruction counter and MUL operand latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_PASS;
            cnt_r   <= 17'd0;
            rd_r    <= 4'd0;
            rs_r    <= 4'd0;
            imm_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_PASS: begin
                    if (if_valid && is_mul_s) begin
                        rd_r    <= if_instr[24:21];
                        rs_r    <= if_instr[20:17];
                        imm_r   <= if_instr[15:0];
                        // imm==0 yields a single SUB; otherwise MOV plus imm ADDs
                        cnt_r   <= (if_instr[15:0] == 16'd0) ? 17'd1
                                                             : {1'b0, if_instr[15:0]} + 17'd1;
                        state_r <= ST_INJECT;
                    end
                end
                ST_INJECT: begin
                    cnt_r <= cnt_r - 17'd1;
                    if (cnt_r == 17'd1) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_PASS;
                end
                default: begin
                    state_r <= ST_PASS;
                end
            endcase
        end
    end

`ifdef UCODE_ISSUE_CHECK_EN
    localparam logic [6:0] OP_MOV = 7'b0000000;
    localparam logic [6:0] OP_ADD = 7'b0110001;
    localparam logic [6:0] OP_SUB = 7'b0110010;

    logic       first_r;
    logic [6:0] exp_op_s;
    logic       err_hit_s;

    always_comb begin
        exp_op_s  = OP_ADD;
        err_hit_s = 1'b0;
        if (imm_r == 16'd0) begin
            exp_op_s = OP_SUB;
        end else if (first_r) begin
            exp_op_s = OP_MOV;
        end else begin
            exp_op_s = OP_ADD;
        end
        if (state_r == ST_INJECT) begin
            err_hit_s = (ucode_instr[31:25] != exp_op_s);
        end else if (state_r == ST_DRAIN) begin
            err_hit_s = (ucode_instr != NOP_INSTR);
        end else begin
            err_hit_s = 1'b0;
        end
    end

    // First-INJECT-cycle flag and sticky sequencer error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_r   <= 1'b0;
            ucode_err <= 1'b0;
        end else begin
            first_r   <= (state_r == ST_PASS) && if_valid && is_mul_s;
            ucode_err <= ucode_err | err_hit_s;
        end
    end
`endif

endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Scoreboard bench for ucode_issue_ctrl with a behavioural microcode sequencer.
module tb_ucode_issue_ctrl;

    localparam logic [31:0] NOP  = 32'hC800_0000;
    localparam logic [31:0] MASK = 32'h0600_0000;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_ready;
    logic        start_mul;
    logic [3:0]  dest_reg;
    logic [3:0]  source_reg;
    logic [15:0] immediate;
    logic [31:0] ucode_instr;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ucode_busy;
`ifdef UCODE_ISSUE_CHECK_EN
    logic        ucode_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic        corrupt;
    logic [15:0] seq_rem;
    logic [3:0]  seq_rd;
    logic [3:0]  seq_rs;

    ucode_issue_ctrl dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
        .if_ready(if_ready), .start_mul(start_mul), .dest_reg(dest_reg),
        .source_reg(source_reg), .immediate(immediate), .ucode_instr(ucode_instr),
        .id_instr(id_instr), .id_valid(id_valid), .ucode_busy(ucode_busy)
`ifdef UCODE_ISSUE_CHECK_EN
        , .ucode_err(ucode_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_mov(input logic [3:0] rd);
        return {7'b0000000, rd, 21'd0};
    endfunction
    function automatic logic [31:0] mk_add(input logic [3:0] rd, input logic [3:0] rs);
        return {7'b0110001, rd, rd, rs, 13'd0};
    endfunction
    function automatic logic [31:0] mk_sub(input logic [3:0] rd);
        return {7'b0110010, rd, rd, rd, 13'd0};
    endfunction
    function automatic logic [31:0] mk_mul(input logic [3:0] rd, input logic [3:0] rs,
                                           input logic [15:0] imm);
        return {7'b0110011, rd, rs, 1'b0, imm};
    endfunction

    // Behavioural sequencer: first instruction one cycle after start_mul, then NOP (halt)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ucode_instr <= NOP;
            seq_rem     <= 16'd0;
            seq_rd      <= 4'd0;
            seq_rs      <= 4'd0;
        end else if (start_mul) begin
            ucode_instr <= (immediate == 16'd0) ? (mk_sub(dest_reg) ^ (corrupt ? MASK : 32'd0))
                                                : mk_mov(dest_reg);
            seq_rem     <= immediate;
            seq_rd      <= dest_reg;
            seq_rs      <= source_reg;
        end else if (seq_rem != 16'd0) begin
            ucode_instr <= mk_add(seq_rd, seq_rs);
            seq_rem     <= seq_rem - 16'd1;
        end else begin
            ucode_instr <= NOP;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid ID instruction must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && id_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL id_instr: got %h, expected nothing at %0t", id_instr, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (id_instr !== e) begin
                    n_err++;
                    $display("FAIL id_instr: got %h, expected %h at %0t", id_instr, e, $time);
                end
            end
        end
    end

    task automatic pass_cycle(input logic [31:0] ins);
        @(posedge clk); #1;
        if_instr = ins;
        if_valid = 1'b1;
        exp_q.push_back(ins);
        @(negedge clk);
        chk("pass_if_ready", {31'd0, if_ready}, 32'd1);
        chk("pass_id_valid", {31'd0, id_valid}, 32'd1);
        chk("pass_start", {31'd0, start_mul}, 32'd0);
    endtask

    // MUL at T, then N inject cycles and one drain cycle while hold_ins waits on IF
    task automatic mul_cycle(input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm,
                             input logic [31:0] hold_ins, input logic hold_valid);
        int n;
        n = (imm == 16'd0) ? 1 : int'(imm) + 1;
        @(posedge clk); #1;
        if_instr = mk_mul(rd, rs, imm);
        if_valid = 1'b1;
        if (imm == 16'd0) begin
            exp_q.push_back(mk_sub(rd));
        end else begin
            exp_q.push_back(mk_mov(rd));
            for (int i = 0; i < int'(imm); i++) exp_q.push_back(mk_add(rd, rs));
        end
        @(negedge clk);
        chk("T_start", {31'd0, start_mul}, 32'd1);
        chk("T_if_ready", {31'd0, if_ready}, 32'd1);
        chk("T_id_valid", {31'd0, id_valid}, 32'd0);
        chk("T_id_instr", id_instr, NOP);
        chk("T_dest", {28'd0, dest_reg}, {28'd0, rd});
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clk); #1;
            if_instr = hold_ins;
            if_valid = hold_valid;
            @(negedge clk);
            chk("busy", {31'd0, ucode_busy}, 32'd1);
            chk("hold_if_ready", {31'd0, if_ready}, 32'd0);
            chk("hold_start", {31'd0, start_mul}, 32'd0);
            chk("hold_ops", {8'd0, dest_reg, source_reg, immediate}, {8'd0, rd, rs, imm});
            if (k <= n) begin
                chk("inject_valid", {31'd0, id_valid}, 32'd1);
            end else begin
                chk("drain_valid", {31'd0, id_valid}, 32'd0);
                chk("drain_instr", id_instr, NOP);
            end
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_busy", {31'd0, ucode_busy}, 32'd0);
        chk("rst_start", {31'd0, start_mul}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'd0;
        corrupt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                if_instr = mk_mul(4'd1, 4'd2, 16'd3);
                if_valid = 1'b1;
            end
            @(negedge clk);
            chk_reset_outs();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        chk("rel_if_ready", {31'd0, if_ready}, 32'd1);
        chk("rel_id_instr", id_instr, NOP);

        for (int i = 0; i < 10; i++) begin
            pass_cycle((i % 2 == 0) ? mk_add(4'(i), 4'(i + 3)) : mk_mov(4'(i)));
        end

        mul_cycle(4'd1, 4'd0, 16'd3, mk_add(4'd7, 4'd8), 1'b1);
        pass_cycle(mk_add(4'd7, 4'd8));
        mul_cycle(4'd2, 4'd5, 16'd0, 32'd0, 1'b0);
        pass_cycle(mk_mov(4'd9));
        mul_cycle(4'd2, 4'd5, 16'd1, 32'd0, 1'b0);
        pass_cycle(mk_mov(4'd10));

        // Back-to-back MULs: the second waits on IF until PASS
        mul_cycle(4'd3, 4'd4, 16'd2, mk_mul(4'd6, 4'd7, 16'd1), 1'b1);
        mul_cycle(4'd6, 4'd7, 16'd1, mk_add(4'd1, 4'd1), 1'b1);
        pass_cycle(mk_add(4'd1, 4'd1));

        // Reset in the middle of a MUL with imm=5
        @(posedge clk); #1;
        if_instr = mk_mul(4'd5, 4'd6, 16'd5);
        if_valid = 1'b1;
        exp_q.push_back(mk_mov(4'd5));
        @(negedge clk);
        chk("mr_start", {31'd0, start_mul}, 32'd1);
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("mr_busy", {31'd0, ucode_busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_rel_busy", {31'd0, ucode_busy}, 32'd0);
        mul_cycle(4'd6, 4'd7, 16'd1, 32'd0, 1'b0);
        pass_cycle(mk_mov(4'd2));

`ifdef UCODE_ISSUE_CHECK_EN
        chk("err_clean", {31'd0, ucode_err}, 32'd0);
        @(posedge clk); #1;
        corrupt = 1'b1;
        if_instr = mk_mul(4'd1, 4'd2, 16'd0);
        if_valid = 1'b1;
        exp_q.push_back(mk_sub(4'd1) ^ MASK);
        @(negedge clk);
        @(posedge clk); #1;
        if_valid = 1'b0;
        corrupt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("err_sticky", {31'd0, ucode_err}, 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("err_rst", {31'd0, ucode_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ucode_issue_ctrl.md
Name: ucode_issue_ctrl

Overview:
- Sits between the IF stage and the ID stage.
- Detects MUL instructions in the fetched stream and takes them out of the stream.
- Pulses start_mul to the microcode sequencer and holds its operands stable.
- Stalls fetch while the sequencer's MOV/ADD/SUB stream is muxed into ID, then returns control to IF once the sequencer is idle again.

Parameters:
- MUL_OPCODE, 7'b0110011: opcode in bits [31:25] that marks a MUL.
- NOP_INSTR, 32'hC800_0000: instruction driven to ID when no valid instruction is issued.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_instr  in  32  instruction from IF
- if_valid  in  1  if_instr valid
- if_ready  out  1  IF may advance (instruction accepted this cycle)
- start_mul  out  1  one-cycle start pulse to the microcode sequencer
- dest_reg  out  4  MUL Rd to the sequencer
- source_reg  out  4  MUL Rs to the sequencer
- immediate  out  16  MUL multiplier to the sequencer
- ucode_instr  in  32  sequencer output_instruction
- id_instr  out  32  instruction to ID
- id_valid  out  1  id_instr valid
- ucode_busy  out  1  microcode sequence in progress

Behaviour:
- MUL format: [31:25] opcode, [24:21] Rd, [20:17] Rs, [16] 0, [15:0] imm.
- is_mul = (if_instr[31:25] == MUL_OPCODE).
- ID never backpressures. An injected instruction is consumed every cycle.
- States: PASS, INJECT, DRAIN.
- PASS:
  - if_ready = 1.
  - id_instr = if_instr.
  - id_valid = if_valid & ~is_mul.
  - dest_reg, source_reg and immediate are driven combinationally from the if_instr fields.
- PASS, if_valid & is_mul (cycle T):
  - Instruction is accepted (if_ready = 1) but not forwarded (id_valid = 0).
  - start_mul = 1, combinational, this cycle only.
  - Rd, Rs and imm are latched.
  - Remaining counter is loaded with N = (imm == 0) ? 1 : imm + 1. The counter is 17 bits, so imm = 16'hFFFF gives N = 65536 with no overflow.
  - Next state is INJECT.
- INJECT (cycles T+1 .. T+N):
  - if_ready = 0.
  - id_instr = ucode_instr, id_valid = 1.
  - start_mul = 0.
  - dest_reg, source_reg and immediate come from the latched values, held stable.
  - The counter decrements each cycle. When it reaches 1, the next state is DRAIN.
- DRAIN (cycle T+N+1):
  - The sequencer is in its halt cycle and ignores start.
  - if_ready = 0, id_valid = 0, id_instr = NOP_INSTR.
  - Next state is PASS. A MUL may start at T+N+2 at the earliest.
- Sequencer contract:
  - imm == 0 gives one SUB Rd,Rd,Rd.
  - imm > 0 gives one MOV Rd,#0 followed by imm ADD Rd,Rd,Rs.
  - The first instruction appears one cycle after start_mul.
- ucode_busy = 1 in INJECT and DRAIN.
- Whenever id_valid = 0, id_instr = NOP_INSTR.
- A non-MUL instruction in PASS passes through with 0 latency, combinationally.
- Back-to-back MULs: the second MUL waits on IF (if_ready = 0) until PASS, then is accepted normally.
- Reset while asserted or mid-operation:
  - State returns to PASS, counter and latches are cleared.
  - start_mul = 0, ucode_busy = 0, id_valid = 0, id_instr = NOP_INSTR, if_ready = 0.
  - The sequencer shares rst, so both blocks resynchronise.

Optional Feature:
- Macro: UCODE_ISSUE_CHECK_EN.
- When defined:
  - Adds output ucode_err (1 bit, reset 0, sticky until rst).
  - It is set on any INJECT cycle where ucode_instr[31:25] is not the expected opcode: SUB 7'b0110010 when imm == 0; MOV 7'b0000000 on the first cycle when imm > 0; ADD 7'b0110001 on later cycles.
  - It is also set if ucode_instr != NOP_INSTR during DRAIN.
- When undefined: no port, no checking logic.

Test Plan:
- Reset held 3 cycles, then released with if_valid = 0:
  - During reset: id_valid = 0, id_instr = 32'hC800_0000, ucode_busy = 0, start_mul = 0.
  - After release: if_ready = 1.
- Non-MUL stream of ADD and MOV, one per cycle, for 10 cycles: each appears on id_instr in the same cycle with id_valid = 1 and if_ready = 1 throughout.
- MUL R1,R0,#3 at T:
  - T: start_mul = 1.
  - T+1..T+4: id_instr = MOV R1, then ADD R1,R1,R0 three times, id_valid = 1, if_ready = 0.
  - T+5: DRAIN, id_valid = 0.
  - T+6: PASS, and the next instruction is accepted.
- MUL R2,R5,#0: one SUB R2,R2,R2 at T+1, DRAIN at T+2, PASS at T+3. MUL R2,R5,#1: MOV then one ADD, PASS at T+4.
- Two consecutive MULs presented at T (imm = 2) and T+1 onward (imm = 1):
  - The second MUL is held until T+5.
  - start_mul pulses exactly at T and T+5.
  - Operands stay at the first MUL's values during T+1..T+4.
- rst asserted at T+2 of a MUL with imm = 5: all outputs return to reset values immediately. After release, a new MUL with imm = 1 runs the correct 2-instruction sequence. With UCODE_ISSUE_CHECK_EN, a forced wrong opcode sets ucode_err, and ucode_err stays set until rst.
